// File: rtl/therm_conv_scheduler.sv
// Round-robin scheduler sharing one binary-to-thermometer converter among
// NUM_REQ requesters; returns registered thermometer code, id, sat flag and a count.
module therm_conv_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned INPUT_WIDTH = 3,
  localparam int unsigned THERM_WIDTH = (2 ** INPUT_WIDTH) - 1,
  localparam int unsigned ID_WIDTH    = $clog2(NUM_REQ),
  localparam int unsigned BIN_WIDTH   = INPUT_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*BIN_WIDTH-1:0]   req_binary,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [THERM_WIDTH-1:0]         out_therm,
  output logic [ID_WIDTH-1:0]            out_id,
  output logic                           out_sat,
  output logic                           busy,
  output logic [15:0]                    conv_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ID_WIDTH-1:0]    r_rr_ptr;
  logic [BIN_WIDTH-1:0]   r_bin;
  logic [ID_WIDTH-1:0]    r_id;
  logic                   r_out_valid;
  logic [THERM_WIDTH-1:0] r_out_therm;
  logic [ID_WIDTH-1:0]    r_out_id;
  logic                   r_out_sat;
  logic                   r_busy;
  logic [15:0]            r_conv_count;

  logic                   w_grant_en;
  logic                   w_found;
  logic [ID_WIDTH-1:0]    w_sel;
  logic [ID_WIDTH-1:0]    w_idx;
  logic [ID_WIDTH-1:0]    w_rr_next;
  logic                   w_hs;
  logic [NUM_REQ-1:0]     w_req_ready;
  logic [BIN_WIDTH-1:0]   w_sel_bin;
  logic [THERM_WIDTH-1:0] w_therm;
  logic                   w_sat;

  // Grants open in IDLE, or in HOLD on the same edge the result is retired
  assign w_grant_en = rst_n && ((r_state == ST_IDLE) ||
                                ((r_state == ST_HOLD) && out_ready));

  // Round-robin pick: first valid requester at or after r_rr_ptr
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_WIDTH'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_req_ready = '0;
    if (w_grant_en && w_found) begin
      w_req_ready[w_sel] = 1'b1;
    end
  end

  assign w_hs      = w_grant_en && w_found;
  assign w_rr_next = ID_WIDTH'((32'(w_sel) + 32'd1) % NUM_REQ);
  assign w_sel_bin = req_binary[32'(w_sel)*BIN_WIDTH +: BIN_WIDTH];

  // Shared converter, fed only from the captured bin register; large values saturate
  always_comb begin
    w_therm = '0;
    for (int unsigned j = 0; j < THERM_WIDTH; j++) begin
      w_therm[j] = (r_bin > BIN_WIDTH'(j));
    end
  end

  assign w_sat = r_bin[INPUT_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_bin        <= '0;
      r_id         <= '0;
      r_out_valid  <= 1'b0;
      r_out_therm  <= '0;
      r_out_id     <= '0;
      r_out_sat    <= 1'b0;
      r_busy       <= 1'b0;
      r_conv_count <= '0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_conv_count <= r_conv_count + 16'd1;
      end
      if (w_hs) begin
        r_bin    <= w_sel_bin;
        r_id     <= w_sel;
        r_rr_ptr <= w_rr_next;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_state <= ST_CONV;
            r_busy  <= 1'b1;
          end
        end
        ST_CONV: begin
          r_out_therm <= w_therm;
          r_out_sat   <= w_sat;
          r_out_id    <= r_id;
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_hs) begin
              r_state <= ST_CONV;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = w_req_ready;
  assign out_valid  = r_out_valid;
  assign out_therm  = r_out_therm;
  assign out_id     = r_out_id;
  assign out_sat    = r_out_sat;
  assign busy       = r_busy;
  assign conv_count = r_conv_count;

endmodule

// File: tb/tb_therm_conv_scheduler.sv
// Randomized self-checking bench for therm_conv_scheduler against a
// transaction-level reference model.
module tb_therm_conv_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned TW = (2 ** IW) - 1;
  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned BW = IW + 1;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*BW-1:0]   req_binary;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [TW-1:0]     out_therm;
  logic [IDW-1:0]    out_id;
  logic              out_sat;
  logic              busy;
  logic [15:0]       conv_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending conversion, presented result, rr pointer, count
  int m_rr, m_pend, m_val, m_bin, m_id, m_therm, m_oid, m_sat, m_count;

  therm_conv_scheduler #(.NUM_REQ(N), .INPUT_WIDTH(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_binary (req_binary),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_therm  (out_therm),
    .out_id     (out_id),
    .out_sat    (out_sat),
    .busy       (busy),
    .conv_count (conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int therm_of(input int v);
    if (v >= (1 << IW)) return (1 << TW) - 1;
    return (1 << v) - 1;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_pend = 0; m_val = 0; m_bin = 0; m_id = 0;
    m_therm = 0; m_oid = 0; m_sat = 0; m_count = 0;
  endtask

  // One clock cycle: drive, check outputs and grant, then advance the model
  task automatic step(input logic [N-1:0] v, input logic [N*BW-1:0] b, input logic rdy);
    int g;
    int en;
    int idx;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    req_valid  = v;
    req_binary = b;
    out_ready  = rdy;
    #1;
    chk("out_valid", 32'(out_valid), m_val);
    chk("busy", 32'(busy), (m_val != 0 || m_pend != 0) ? 1 : 0);
    chk("conv_count", 32'(conv_count), m_count);
    if (m_val != 0) begin
      chk("out_therm", 32'(out_therm), m_therm);
      chk("out_id", 32'(out_id), m_oid);
      chk("out_sat", 32'(out_sat), m_sat);
    end
    en = ((m_pend == 0 && m_val == 0) || (m_val != 0 && rdy)) ? 1 : 0;
    g = -1;
    if (en != 0) begin
      for (int k = 0; k < int'(N); k++) begin
        idx = (m_rr + k) % int'(N);
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (m_val != 0 && rdy) m_count = (m_count + 1) % 65536;
    if (m_pend != 0) begin
      m_val   = 1;
      m_therm = therm_of(m_bin);
      m_oid   = m_id;
      m_sat   = (m_bin >= (1 << IW)) ? 1 : 0;
      m_pend  = 0;
    end else if (m_val != 0 && rdy) begin
      m_val = 0;
    end
    if (g >= 0) begin
      m_pend = 1;
      m_bin  = int'(b[g*BW +: BW]);
      m_id   = g;
      m_rr   = (g + 1) % int'(N);
    end
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step('0, '0, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '1;
    req_binary = '0;
    out_ready  = 1'b1;
    model_reset();
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_therm", 32'(out_therm), 0);
    chk("rst_count", 32'(conv_count), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    chk("rst_req_ready_hold", 32'(req_ready), 0);
    req_valid = '0;
    rst_n = 1'b1;

    // Single request of value 3 from requester 0
    step(4'b0001, {4'd0, 4'd0, 4'd0, 4'd3}, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("plan1_therm", 32'(out_therm), 32'h07);
    drain(2);
    chk("plan1_count", 32'(conv_count), 1);

    // All four requesters valid, back-to-back service
    for (int i = 0; i < 8; i++) step(4'b1111, {4'd7, 4'd5, 4'd2, 4'd1}, 1'b1);
    drain(3);
    chk("plan2_count", 32'(conv_count), 5);

    // Saturation, then zero
    step(4'b0010, {4'd0, 4'd0, 4'd8, 4'd0}, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("plan3_sat", 32'(out_sat), 1);
    chk("plan3_therm", 32'(out_therm), 32'h7F);
    step(4'b0010, {4'd0, 4'd0, 4'd0, 4'd0}, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("plan3_zero_valid", 32'(out_valid), 1);
    chk("plan3_zero_therm", 32'(out_therm), 0);
    drain(2);

    // Back-pressure in HOLD with another request waiting
    step(4'b0001, {4'd0, 4'd0, 4'd0, 4'd5}, 1'b1);
    step(4'b0100, {4'd0, 4'd4, 4'd0, 4'd0}, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0100, {4'd0, 4'd4, 4'd0, 4'd0}, 1'b0);
    step(4'b0100, {4'd0, 4'd4, 4'd0, 4'd0}, 1'b1);
    drain(4);

    // Reset while a conversion is in flight
    step(4'b1000, {4'd6, 4'd0, 4'd0, 4'd0}, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    model_reset();
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_count", 32'(conv_count), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1001, {4'd6, 4'd0, 4'd0, 4'd2}, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("midrst_first_id", 32'(out_id), 0);
    drain(3);

    // Counter wrap at 16 bits
    @(negedge clk);
    force dut.r_conv_count = 16'hFFFF;
    #1;
    release dut.r_conv_count;
    m_count = 65535;
    step(4'b0001, {4'd0, 4'd0, 4'd0, 4'd1}, 1'b1);
    drain(3);
    chk("wrap_count", 32'(conv_count), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(N'($urandom), (N*BW)'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    drain(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
